// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: shifts a captured operand by up to STEP
// positions per clock (SLL/SRL/SRA/ROR) and pulses done with the result.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // STEP may equal WIDTH, so compare in one extra bit.
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    rem;
  logic [1:0]       mode;
  logic [SW-1:0]    k;
  logic [SW-1:0]    rot_amt;
  logic [WIDTH-1:0] shifted;

  // Per-cycle shift: k = min(STEP, remaining), applied in the captured mode.
  // SRA uses the working MSB, which always equals the captured sign bit.
  always_comb begin
    k       = ({1'b0, rem} > STEP_W) ? SW'(STEP) : rem;
    rot_amt = SW'(0) - k;
    shifted = work;
    case (mode)
      OP_SLL: shifted = work << k;
      OP_SRL: shifted = work >> k;
      OP_SRA: shifted = $unsigned($signed(work) >>> k);
      OP_ROR: shifted = (work >> k) | (work << rot_amt);
      default: shifted = work;
    endcase
  end

  // State register plus registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == k) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, computed from the next state so busy/done are registered.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt != IDLE) busy_nxt = 1'b1;
    if (state_nxt == DONE) done_nxt = 1'b1;
  end

  // Operand capture, iterative shifting and result latching on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      rem  <= '0;
      mode <= OP_SLL;
      res  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= data;
            rem  <= shamt;
            mode <= op;
            if (shamt == '0) res <= data;
          end
        end
        SHIFT: begin
          work <= shifted;
          rem  <= rem - k;
          if (rem == k) res <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter, STEP=1 and STEP=4 instances.
module tb_seq_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev [2];

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .data(data),
    .shamt(shamt), .busy(busy1), .done(done1), .res(res1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .data(data),
    .shamt(shamt), .busy(busy4), .done(done4), .res(res4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 0) ? done1 : done4;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy1 : busy4;
  endfunction

  function automatic logic [31:0] get_res(input int w);
    return (w == 0) ? res1 : res4;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) start1 = v;
    else        start4 = v;
  endtask

  // Issue one op (called at a negedge), scramble inputs after acceptance,
  // optionally keep start high with junk operands through the DONE cycle.
  task automatic do_op(input int w, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp, input int lat,
                       input bit junk, input string tag);
    int cyc;
    op = o; data = d; shamt = s;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, junk);
    op = ~o; data = ~d; shamt = ~s;
    cyc = 1;
    while (!get_done(w) && cyc < 64) begin
      check({tag, " busy"}, 32'(get_busy(w)), 32'd1);
      check({tag, " hold"}, get_res(w), prev[w]);
      @(negedge clk);
      cyc++;
    end
    check({tag, " lat"}, 32'(cyc), 32'(lat));
    check({tag, " res"}, get_res(w), exp);
    check({tag, " busy_done"}, 32'(get_busy(w)), 32'd1);
    @(negedge clk);
    set_start(w, 1'b0);
    check({tag, " done_pulse"}, 32'(get_done(w)), 32'd0);
    check({tag, " idle"}, 32'(get_busy(w)), 32'd0);
    check({tag, " res_keep"}, get_res(w), exp);
    prev[w] = exp;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = SLL; data = '0; shamt = '0;
    prev[0] = '0; prev[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy1", 32'(busy1), 32'd0);
    check("rst done1", 32'(done1), 32'd0);
    check("rst res1", res1, 32'd0);
    check("rst busy4", 32'(busy4), 32'd0);
    check("rst res4", res4, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  1'b0, "sra1_s4");
    do_op(0, ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 2,  1'b0, "ror1_s1");
    do_op(1, SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 9,  1'b0, "srl4_s31");
    do_op(0, SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1,  1'b0, "sll1_s0");
    do_op(1, SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1,  1'b0, "sll4_s0");
    do_op(0, SLL, 32'h0000_0001, 5'd3,  32'h0000_0008, 4,  1'b1, "sll1_busy_start");
    do_op(1, ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 3,  1'b0, "ror4_s8");
    do_op(1, SRA, 32'h8000_0001, 5'd5,  32'hFC00_0000, 3,  1'b1, "sra4_s5");
    do_op(0, ROR, 32'h0000_00F0, 5'd4,  32'h0000_000F, 5,  1'b0, "ror1_s4");
    do_op(1, ROR, 32'hABCD_0001, 5'd31, 32'h579A_0003, 9,  1'b0, "ror4_s31");
    do_op(1, SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 9,  1'b0, "sll4_s31");
    do_op(0, SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 32, 1'b0, "sra1_pos_s31");
    do_op(1, SRA, 32'h4000_0000, 5'd3,  32'h0800_0000, 2,  1'b0, "sra4_pos_s3");
    do_op(1, SRA, 32'hF000_0000, 5'd30, 32'hFFFF_FFFF, 9,  1'b0, "sra4_s30");
    do_op(0, SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 32, 1'b0, "srl1_s31");

    // Abort a long SRA with reset; start is also high during reset.
    op = SRA; data = 32'h8000_0000; shamt = 5'd20; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(busy1), 32'd1);
    rst = 1'b1; start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    check("abort busy", 32'(busy1), 32'd0);
    check("abort done", 32'(done1), 32'd0);
    check("abort res", res1, 32'd0);
    check("abort res4", res4, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort no_done", 32'(done1), 32'd0);
      check("abort stay_idle", 32'(busy1), 32'd0);
    end
    prev[0] = '0; prev[1] = '0;
    do_op(0, SRL, 32'h0000_0100, 5'd8, 32'h0000_0001, 9, 1'b0, "srl1_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, 8 or greater.
REQ-002 Parameter STEP, default 1, maximum bit positions shifted per cycle; SHALL be a power of two, 1 to WIDTH.
REQ-003 Localparam SW = log2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a shift; sampled only when busy=0.
REQ-007 op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-008 data  input  WIDTH  operand, captured on accepted start.
REQ-009 shamt  input  SW  shift amount, unsigned, captured on accepted start.
REQ-010 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-011 done  output  1  one-cycle pulse; res is valid in this cycle.
REQ-012 res  output  WIDTH  registered result.

Function
REQ-013 States: IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE with start=1: capture data into the working register, op, and shamt into the remaining-count register.
REQ-015 On an accepted start, go to SHIFT if shamt != 0, else go to DONE.
REQ-016 SHIFT: each cycle, shift the working register by k = min(STEP, remaining) in the captured mode, then subtract k from remaining.
REQ-017 SHIFT: the cycle in which remaining becomes 0 SHALL transition to DONE.
REQ-018 SLL fills with 0 from the LSB; SRL fills with 0 from the MSB.
REQ-019 SRA fills with the captured data[WIDTH-1], replicated.
REQ-020 ROR moves bits shifted out of the LSB into the MSB.
REQ-021 The final res SHALL equal the single-step combinational result for the captured op, data and shamt.
REQ-022 DONE: done=1 and res = working register for exactly one cycle, then return to IDLE.
REQ-023 Latency from the accepting edge to the done cycle SHALL be ceil(shamt/STEP)+1 cycles; shamt=0 gives 1 cycle.
REQ-024 start while busy=1 (including the DONE cycle) SHALL be ignored with no effect on state or captured operands.
REQ-025 A start in the cycle after DONE (IDLE again) SHALL be accepted; back-to-back throughput is one op per latency+1 cycles.
REQ-026 Changes to op, data or shamt after acceptance SHALL not affect the operation in progress.
REQ-027 res SHALL hold its value from the last DONE until the next DONE; it SHALL not change during SHIFT.
REQ-028 Shift amounts are less than WIDTH by construction; no over-shift handling is required.

Reset
REQ-029 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, res=0, and clear the working and count registers.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL behave normally.

Verification
REQ-032 STEP=1, SRA, data=0x80000000, shamt=4 -> res=0xF8000000; done on the 5th cycle after acceptance.
REQ-033 STEP=1, ROR, data=0x00000001, shamt=1 -> res=0x80000000; done on the 2nd cycle after acceptance.
REQ-034 STEP=4, SRL, data=0xFFFFFFFF, shamt=31 -> res=0x00000001; done on the 9th cycle after acceptance.
REQ-035 SLL, data=0x12345678, shamt=0 -> res=0x12345678; done on the 1st cycle after acceptance; busy high for exactly 1 cycle.
REQ-036 Start SLL data=0x1 shamt=3, then pulse start with data=0xFFFF shamt=1 during SHIFT -> second start ignored; res=0x00000008, single done pulse.
REQ-037 rst pulse during SHIFT of SRA shamt=20 -> no done, res=0, busy=0; a following SRL 0x100 shamt=8 -> res=0x00000001.
